pps_trig_gen: RTL and testbench

PPS_TRIG_GEN -- requirements
Module: pps_trig_gen

---
 rtl/pps_trig_gen.sv | 193 +++++++++++++++++++
 tb/tb_pps_trig_gen.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pps_trig_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pps_trig_gen                                                    |
// | Purpose  : Pulse-per-second generator and one-shot time trigger driven by  |
// |            a PTP real-time clock (seconds + nanoseconds).                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pps_trig_gen #(
    parameter logic [31:0] PW_RST_NS = 32'd100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] time_ptp_ns,
    input  logic [47:0] time_ptp_sec,
    input  logic        pps_en,
    input  logic        pw_ld,
    input  logic [31:0] pw_ns_in,
    input  logic        trig_arm,
    input  logic        trig_cancel,
    input  logic [47:0] trig_sec_in,
    input  logic [31:0] trig_ns_in,
    output logic        pps_out,
    output logic [47:0] pps_sec_out,
    output logic        trig_out,
    output logic        trig_armed,
    output logic        trig_done,
    output logic        trig_late,
    output logic        time_jump
);

    localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_FIRE  = 2'd2;

    // ------------------------------------------------------------------
    // Second-boundary classification
    // ------------------------------------------------------------------
    logic [47:0] sec_prev;
    logic        sec_valid;     // sec_prev holds a real sample (not the reset value)
    logic        sec_roll;
    logic        sec_jump;

    logic [31:0] pw_reg;
    logic        pw_end;        // programmed width has elapsed in this second
    logic        pps_restart;   // pulse was still high at rollover: re-assert next cycle

    assign sec_roll = sec_valid && (time_ptp_sec == sec_prev + 48'd1);
    assign sec_jump = sec_valid && (time_ptp_sec != sec_prev) && !sec_roll;

    // A width of a full second or more never ends inside the second; the
    // pulse is only broken for one cycle at the following rollover.
    assign pw_end = (pw_reg < NS_PER_SEC) && (time_ptp_ns >= pw_reg);

    // Second tracking, width register and PPS pulse shaping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec_prev    <= '0;
            sec_valid   <= 1'b0;
            pw_reg      <= PW_RST_NS;
            pps_restart <= 1'b0;
            pps_out     <= 1'b0;
            pps_sec_out <= '0;
            time_jump   <= 1'b0;
        end else begin
            sec_prev  <= time_ptp_sec;
            sec_valid <= 1'b1;
            time_jump <= sec_jump;

            if (pw_ld) begin
                pw_reg <= pw_ns_in;
            end

            if (sec_jump || !pps_en) begin
                pps_out     <= 1'b0;
                pps_restart <= 1'b0;
            end else if (sec_roll && pps_out) begin
                pps_out     <= 1'b0;
                pps_restart <= 1'b1;
            end else if (sec_roll || pps_restart) begin
                pps_out     <= 1'b1;
                pps_restart <= 1'b0;
                pps_sec_out <= time_ptp_sec;
            end else if (pps_out && pw_end) begin
                pps_out <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Trigger FSM
    // ------------------------------------------------------------------
    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [47:0] trig_sec;
    logic [31:0] trig_ns;
    logic        arm_first;     // first ARMED cycle after a capture

    logic [47:0] trig_sec_nxt;
    logic [31:0] trig_ns_nxt;
    logic        arm_first_nxt;
    logic        trig_out_nxt;
    logic        trig_armed_nxt;
    logic        trig_done_nxt;
    logic        trig_late_nxt;
    logic        capture;
    logic        time_ge_tgt;

    assign time_ge_tgt = {time_ptp_sec, time_ptp_ns} >= {trig_sec, trig_ns};

    // State register together with the registered trigger outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            trig_sec   <= '0;
            trig_ns    <= '0;
            arm_first  <= 1'b0;
            trig_out   <= 1'b0;
            trig_armed <= 1'b0;
            trig_done  <= 1'b0;
            trig_late  <= 1'b0;
        end else begin
            state      <= state_nxt;
            trig_sec   <= trig_sec_nxt;
            trig_ns    <= trig_ns_nxt;
            arm_first  <= arm_first_nxt;
            trig_out   <= trig_out_nxt;
            trig_armed <= trig_armed_nxt;
            trig_done  <= trig_done_nxt;
            trig_late  <= trig_late_nxt;
        end
    end

    // Next-state decision; cancel always wins over arm and over a due fire
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!trig_cancel && trig_arm) begin
                    state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (trig_cancel) begin
                    state_nxt = ST_IDLE;
                end else if (trig_arm) begin
                    state_nxt = ST_ARMED;
                end else if (time_ge_tgt) begin
                    state_nxt = ST_FIRE;
                end
            end
            ST_FIRE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next values of the target register and of the registered outputs
    always_comb begin
        trig_sec_nxt  = trig_sec;
        trig_ns_nxt   = trig_ns;
        arm_first_nxt = 1'b0;
        trig_done_nxt = trig_done;
        trig_late_nxt = trig_late;
        capture       = !trig_cancel && trig_arm &&
                        ((state == ST_IDLE) || (state == ST_ARMED));

        if (capture) begin
            trig_sec_nxt  = trig_sec_in;
            trig_ns_nxt   = trig_ns_in;
            arm_first_nxt = 1'b1;
            trig_done_nxt = 1'b0;
            trig_late_nxt = 1'b0;
        end

        if ((state == ST_ARMED) && (state_nxt == ST_FIRE)) begin
            trig_done_nxt = 1'b1;
            if (arm_first) begin
                trig_late_nxt = 1'b1;
            end
        end

        trig_out_nxt   = (state_nxt == ST_FIRE);
        trig_armed_nxt = (state_nxt != ST_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_pps_trig_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pps_trig_gen                                                 |
// | Purpose  : Self-checking bench for pps_trig_gen with a reference model.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pps_trig_gen;

    localparam logic [31:0] NSEC = 32'd1_000_000_000;

    logic        clk;
    logic        rst;
    logic [31:0] time_ptp_ns;
    logic [47:0] time_ptp_sec;
    logic        pps_en;
    logic        pw_ld;
    logic [31:0] pw_ns_in;
    logic        trig_arm;
    logic        trig_cancel;
    logic [47:0] trig_sec_in;
    logic [31:0] trig_ns_in;
    logic        pps_out;
    logic [47:0] pps_sec_out;
    logic        trig_out;
    logic        trig_armed;
    logic        trig_done;
    logic        trig_late;
    logic        time_jump;

    int tests;
    int fails;

    pps_trig_gen dut (
        .clk          (clk),
        .rst          (rst),
        .time_ptp_ns  (time_ptp_ns),
        .time_ptp_sec (time_ptp_sec),
        .pps_en       (pps_en),
        .pw_ld        (pw_ld),
        .pw_ns_in     (pw_ns_in),
        .trig_arm     (trig_arm),
        .trig_cancel  (trig_cancel),
        .trig_sec_in  (trig_sec_in),
        .trig_ns_in   (trig_ns_in),
        .pps_out      (pps_out),
        .pps_sec_out  (pps_sec_out),
        .trig_out     (trig_out),
        .trig_armed   (trig_armed),
        .trig_done    (trig_done),
        .trig_late    (trig_late),
        .time_jump    (time_jump)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    // ---------------- reference model state ----------------
    logic [47:0] m_last_sec;
    bit          m_have_last;
    logic [31:0] m_pw;
    bit          m_pps;
    bit          m_pend;
    logic [47:0] m_sec_out;
    bit          m_jump;
    int          m_age;      // -1 when not waiting, else cycles waited since arming
    bit          m_tout;
    bit          m_done;
    bit          m_late;
    logic [95:0] m_tgt;      // target as absolute nanoseconds

    logic [95:0] now_l;
    logic [95:0] tgt_l;
    logic [31:0] off;

    function automatic logic [95:0] lin(input logic [47:0] s, input logic [31:0] n);
        return 96'(s) * 96'd1_000_000_000 + 96'(n);
    endfunction

    task automatic model_reset();
        m_last_sec  = '0;
        m_have_last = 0;
        m_pw        = 32'd100_000_000;
        m_pps       = 0;
        m_pend      = 0;
        m_sec_out   = '0;
        m_jump      = 0;
        m_age       = -1;
        m_tout      = 0;
        m_done      = 0;
        m_late      = 0;
        m_tgt       = '0;
    endtask

    task automatic model_edge();
        logic [95:0] t_now;
        bit          rolled;
        bit          jumped;
        t_now  = lin(time_ptp_sec, time_ptp_ns);
        rolled = m_have_last && (time_ptp_sec == m_last_sec + 48'd1);
        jumped = m_have_last && (time_ptp_sec != m_last_sec) && !rolled;

        if (jumped || !pps_en) begin
            m_pps = 0; m_pend = 0;
        end else if (rolled && m_pps) begin
            m_pps = 0; m_pend = 1;
        end else if (rolled || m_pend) begin
            m_pps = 1; m_pend = 0; m_sec_out = time_ptp_sec;
        end else if (m_pps && (m_pw < NSEC) && (time_ptp_ns >= m_pw)) begin
            m_pps = 0;
        end

        if (m_tout) begin
            m_tout = 0; m_age = -1;
        end else if (m_age >= 0) begin
            if (trig_cancel) begin
                m_age = -1;
            end else if (trig_arm) begin
                m_tgt = lin(trig_sec_in, trig_ns_in);
                m_age = 0; m_late = 0; m_done = 0;
            end else if (t_now >= m_tgt) begin
                m_tout = 1; m_done = 1;
                if (m_age == 0) m_late = 1;
                m_age = -1;
            end else begin
                m_age++;
            end
        end else if (trig_arm && !trig_cancel) begin
            m_tgt = lin(trig_sec_in, trig_ns_in);
            m_age = 0; m_late = 0; m_done = 0;
        end

        m_jump = jumped;
        if (pw_ld) m_pw = pw_ns_in;
        m_last_sec  = time_ptp_sec;
        m_have_last = 1;
    endtask

    // ---------------- comparison helpers ----------------
    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk48(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk1 ("pps_out",     pps_out,     m_pps);
        chk48("pps_sec_out", pps_sec_out, m_sec_out);
        chk1 ("time_jump",   time_jump,   m_jump);
        chk1 ("trig_out",    trig_out,    m_tout);
        chk1 ("trig_armed",  trig_armed,  (m_age >= 0) || m_tout);
        chk1 ("trig_done",   trig_done,   m_done);
        chk1 ("trig_late",   trig_late,   m_late);
    endtask

    // One clock: model follows the edge, outputs sampled 1 ns later, strobes drop
    task automatic cyc();
        @(posedge clk);
        if (rst) model_edge();
        else     model_reset();
        #1;
        check_all();
        pw_ld       = 1'b0;
        trig_arm    = 1'b0;
        trig_cancel = 1'b0;
    endtask

    task automatic adv(input logic [31:0] inc);
        time_ptp_ns = time_ptp_ns + inc;
        if (time_ptp_ns >= NSEC) begin
            time_ptp_ns  = time_ptp_ns - NSEC;
            time_ptp_sec = time_ptp_sec + 48'd1;
        end
    endtask

    task automatic set_t(input logic [47:0] s, input logic [31:0] n);
        time_ptp_sec = s;
        time_ptp_ns  = n;
    endtask

    task automatic arm(input logic [47:0] s, input logic [31:0] n);
        trig_arm    = 1'b1;
        trig_sec_in = s;
        trig_ns_in  = n;
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; pps_en = 1'b1; pw_ld = 1'b0; pw_ns_in = '0;
        trig_arm = 1'b0; trig_cancel = 1'b0; trig_sec_in = '0; trig_ns_in = '0;
        set_t(48'd5, 32'd999_999_976);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check_all();
        chk1("rst_pps", pps_out, 1'b0);
        chk1("rst_armed", trig_armed, 1'b0);
        cyc(); cyc();
        rst = 1'b1;

        // first sample after release: sec 5 vs stale 0 must not count as a jump
        cyc();
        chk1("rel_jump", time_jump, 1'b0);
        chk1("rel_pps", pps_out, 1'b0);

        // 5 -> 6 rollover at 8 ns/clk, default 100 ms width
        adv(8); cyc();
        adv(8); cyc();
        adv(8); cyc();
        chk1 ("roll6_pps", pps_out, 1'b1);
        chk48("roll6_sec", pps_sec_out, 48'd6);
        set_t(48'd6, 32'd99_999_992); cyc();
        chk1("pw_before_end", pps_out, 1'b1);
        adv(8); cyc();
        chk1("pw_end", pps_out, 1'b0);

        // all-ones wrap is a rollover; 10 -> 3 is a jump
        set_t(48'hFFFF_FFFF_FFFF, 32'd5); cyc();
        chk1("jump_to_max", time_jump, 1'b1);
        cyc();
        chk1("jump_one_cycle", time_jump, 1'b0);
        set_t(48'd0, 32'd5); cyc();
        chk1 ("wrap_pps", pps_out, 1'b1);
        chk48("wrap_sec", pps_sec_out, 48'd0);
        chk1 ("wrap_nojump", time_jump, 1'b0);
        set_t(48'd10, 32'd5); cyc();
        cyc();
        set_t(48'd3, 32'd5); cyc();
        chk1("jump_10_3", time_jump, 1'b1);
        chk1("jump_pps_low", pps_out, 1'b0);
        cyc();
        chk1("jump_10_3_clr", time_jump, 1'b0);
        chk1("jump_no_pulse", pps_out, 1'b0);

        // on-time trigger {7,500} armed at {7,0}
        set_t(48'd7, 32'd0); cyc();
        arm(48'd7, 32'd500); cyc();
        chk1("arm_armed", trig_armed, 1'b1);
        for (int k = 0; k < 4; k++) begin
            adv(100); cyc();
            chk1("arm_wait", trig_out, 1'b0);
        end
        adv(100); cyc();
        chk1("fire_out", trig_out, 1'b1);
        chk1("fire_done", trig_done, 1'b1);
        chk1("fire_late", trig_late, 1'b0);
        cyc();
        chk1("fire_one_cycle", trig_out, 1'b0);
        chk1("fire_disarmed", trig_armed, 1'b0);

        // late trigger {2,0} armed at {3,40}
        set_t(48'd3, 32'd40); cyc();
        arm(48'd2, 32'd0); cyc();
        chk1("late_first", trig_out, 1'b0);
        cyc();
        chk1("late_fire", trig_out, 1'b1);
        chk1("late_flag", trig_late, 1'b1);
        cyc();
        chk1("late_sticky", trig_late, 1'b1);

        // arm + cancel together while ARMED
        arm(48'd1000, 32'd0); cyc();
        chk1("far_armed", trig_armed, 1'b1);
        arm(48'd1001, 32'd0); trig_cancel = 1'b1; cyc();
        chk1("cancel_prio", trig_armed, 1'b0);
        chk1("cancel_noout", trig_out, 1'b0);
        chk1("cancel_done", trig_done, 1'b0);

        // cancel on the compare-true cycle
        arm(48'd3, 32'd200); cyc();
        set_t(48'd3, 32'd200); trig_cancel = 1'b1; cyc();
        cyc();
        chk1("cancel_due_nofire", trig_out, 1'b0);

        // zero width -> one-cycle pulse
        pw_ld = 1'b1; pw_ns_in = 32'd0;
        set_t(48'd20, 32'd999_999_992); cyc();
        adv(8); cyc();
        chk1("pw0_high", pps_out, 1'b1);
        adv(8); cyc();
        chk1("pw0_low", pps_out, 1'b0);

        // width above one second -> low for one cycle per second
        pw_ld = 1'b1; pw_ns_in = 32'd1_200_000_000;
        set_t(48'd21, 32'd999_999_992); cyc();
        adv(8); cyc();
        chk1("clamp_start", pps_out, 1'b1);
        for (int k = 0; k < 3; k++) begin
            adv(300_000_000); cyc();
            chk1("clamp_hold", pps_out, 1'b1);
        end
        set_t(48'd22, 32'd999_999_992); cyc();
        adv(8); cyc();
        chk1("clamp_gap", pps_out, 1'b0);
        adv(8); cyc();
        chk1 ("clamp_restart", pps_out, 1'b1);
        chk48("clamp_sec", pps_sec_out, 48'd23);

        // reset mid-pulse while armed
        arm(48'd1000, 32'd0); cyc();
        rst = 1'b0;
        model_reset();
        #1;
        chk1("rstmid_pps", pps_out, 1'b0);
        chk1("rstmid_armed", trig_armed, 1'b0);
        check_all();
        cyc();
        rst = 1'b1;
        cyc();
        chk1("rstrel_jump", time_jump, 1'b0);
        chk1("rstrel_pps", pps_out, 1'b0);
        set_t(48'd23, 32'd999_999_992); cyc();
        adv(8); cyc();
        chk1("rstrel_roll", pps_out, 1'b1);
        set_t(48'd24, 32'd99_999_992); cyc();
        adv(8); cyc();
        chk1("rstrel_pw_default", pps_out, 1'b0);

        // randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 99) < 3) time_ptp_sec = 48'($urandom_range(0, 2000));
            else adv(32'($urandom_range(1, 250_000_000)));
            pps_en = ($urandom_range(0, 99) < 95);
            if ($urandom_range(0, 99) < 3) begin
                pw_ld = 1'b1;
                case ($urandom_range(0, 3))
                    0:       pw_ns_in = 32'd0;
                    1:       pw_ns_in = 32'd100_000_000;
                    2:       pw_ns_in = 32'd1_200_000_000;
                    default: pw_ns_in = 32'($urandom_range(1, 999_999_999));
                endcase
            end
            if ($urandom_range(0, 99) < 4) begin
                now_l = lin(time_ptp_sec, time_ptp_ns);
                off   = 32'($urandom_range(0, 1_500_000_000));
                if (($urandom_range(0, 1) == 0) && (now_l >= 96'(off))) tgt_l = now_l - 96'(off);
                else tgt_l = now_l + 96'(off);
                arm(48'(tgt_l / 96'd1_000_000_000), 32'(tgt_l % 96'd1_000_000_000));
            end
            if ($urandom_range(0, 99) < 2) trig_cancel = 1'b1;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
